// File: rtl/mul_pkg.sv
// Shared constants and elaboration-time helpers for the Wallace multiplier.
package mul_pkg;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefStages = 3;

  // Live rows after `level` carry-save levels. Level 0 holds WIDTH partial-product rows
  // plus the Baugh-Wooley constant row.
  function automatic int unsigned rows_at_level(int unsigned width, int unsigned level);
    int unsigned n;
    n = width + 1;
    for (int unsigned l = 0; l < level; l++) begin
      if (n > 2) n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  // Number of 3:2 levels needed to reduce the partial products to two rows.
  function automatic int unsigned wallace_depth(int unsigned width);
    int unsigned n;
    int unsigned d;
    n = width + 1;
    d = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      d++;
    end
    return d;
  endfunction

  // Reduction level (0..depth) after which intermediate register s (1..stages-1) sits.
  // Spacing is even over depth+1 slots, so distinct levels are guaranteed up to
  // stages = depth + 2.
  function automatic int unsigned stage_level(int unsigned s, int unsigned depth,
                                              int unsigned stages);
    return (s * (depth + 1)) / stages;
  endfunction

  function automatic bit is_reg_level(int unsigned level, int unsigned depth,
                                      int unsigned stages);
    for (int unsigned s = 1; s < stages; s++) begin
      if (stage_level(s, depth, stages) == level) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/pipelined_wallace_multiplier_if.sv
// Operand/result handshake bundle for the pipelined multiplier.
interface pipelined_wallace_multiplier_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, result
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/csa_row.sv
// One carry-save 3:2 compression level: three rows in, sum row and carry row out.
// The carry row is already shifted left one place; the carry out of the MSB is
// dropped since the product is kept modulo 2^WIDTH.
module csa_row #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-2:0] cout;

  // Full-adder cell per column except the MSB.
  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ z[i];
    assign cout[i] = (x[i] & y[i]) | (x[i] & z[i]) | (y[i] & z[i]);
  end

  // MSB column: its carry would leave the product width, so only the sum is kept.
  assign sum[WIDTH-1] = x[WIDTH-1] ^ y[WIDTH-1] ^ z[WIDTH-1];

  assign carry = {cout, 1'b0};

endmodule

// File: rtl/pipelined_wallace_multiplier.sv
// Pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed per operand pair.
// A single advance signal moves every stage; registers sit at evenly spaced reduction
// levels and the final carry-propagate add always feeds the result register.
module pipelined_wallace_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages
) (
  input logic                          clk,
  input logic                          rst,
  pipelined_wallace_multiplier_if.slave bus
);

  localparam int unsigned PW      = 2 * WIDTH;
  localparam int unsigned Depth   = wallace_depth(WIDTH);
  localparam int unsigned MaxRows = WIDTH + 1;

  logic              advance;
  logic [STAGES-1:0] valid_q;
  logic [PW-1:0]     pp       [MaxRows];
  logic [PW-1:0]     rows_in  [Depth+1][MaxRows];
  logic [PW-1:0]     rows_out [Depth+1][MaxRows];
  logic [PW-1:0]     product;
  logic [PW-1:0]     result_q;

  // Only a held, unaccepted result stalls; reset always lets the pipe move.
  assign advance = rst | ~(valid_q[STAGES-1] & ~bus.out_ready);

  // Partial products; in signed mode terms with exactly one MSB operand bit are
  // inverted and the constant row carries 1s at bits WIDTH and 2*WIDTH-1.
  always_comb begin
    logic pbit;
    for (int r = 0; r < MaxRows; r++) pp[r] = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pbit = bus.a[j] & bus.b[i];
        if (bus.is_signed && ((i == WIDTH - 1) != (j == WIDTH - 1))) pbit = ~pbit;
        pp[i][i+j] = pbit;
      end
    end
    if (bus.is_signed) begin
      pp[WIDTH][WIDTH]  = 1'b1;
      pp[WIDTH][PW-1]   = 1'b1;
    end
  end

  for (genvar p = 0; p <= Depth; p++) begin : g_lvl
    localparam int unsigned N = rows_at_level(WIDTH, p);

    if (p == 0) begin : g_pp
      for (genvar r = 0; r < MaxRows; r++) begin : g_row
        assign rows_in[0][r] = pp[r];
      end
    end else begin : g_csa
      localparam int unsigned Np = rows_at_level(WIDTH, p - 1);
      localparam int unsigned G  = Np / 3;
      localparam int unsigned R  = Np % 3;

      for (genvar g = 0; g < G; g++) begin : g_grp
        csa_row #(
          .WIDTH(PW)
        ) u_csa (
          .x    (rows_out[p-1][3*g]),
          .y    (rows_out[p-1][3*g+1]),
          .z    (rows_out[p-1][3*g+2]),
          .sum  (rows_in[p][2*g]),
          .carry(rows_in[p][2*g+1])
        );
      end
      // Rows that did not fill a triple pass straight to the next level.
      for (genvar r = 0; r < R; r++) begin : g_pass
        assign rows_in[p][2*G+r] = rows_out[p-1][3*G+r];
      end
      for (genvar r = 2 * G + R; r < MaxRows; r++) begin : g_zero
        assign rows_in[p][r] = '0;
      end
    end

    if (is_reg_level(p, Depth, STAGES)) begin : g_reg
      logic [PW-1:0] bank_q [N];

      // Stage register for the live rows of this level; holds while stalled.
      always_ff @(posedge clk) begin
        if (advance) begin
          for (int r = 0; r < N; r++) bank_q[r] <= rows_in[p][r];
        end
      end

      for (genvar r = 0; r < MaxRows; r++) begin : g_out
        if (r < N) begin : g_live
          assign rows_out[p][r] = bank_q[r];
        end else begin : g_dead
          assign rows_out[p][r] = '0;
        end
      end
    end else begin : g_wire
      for (genvar r = 0; r < MaxRows; r++) begin : g_out
        assign rows_out[p][r] = rows_in[p][r];
      end
    end
  end

  // Final carry-propagate add of the two remaining rows.
  assign product = rows_out[Depth][0] + rows_out[Depth][1];

  // Valid shift chain, one bit per stage register; bubbles are carried, not collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (advance) begin
      for (int s = STAGES - 1; s > 0; s--) valid_q[s] <= valid_q[s-1];
      valid_q[0] <= bus.in_valid;
    end
  end

  // Result register, the last pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (advance) begin
      result_q <= product;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.result    = result_q;

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Directed bench for the pipelined Wallace multiplier (WIDTH=8, STAGES=3).
module tb_pipelined_wallace_multiplier;

  localparam int unsigned W = 8;
  localparam int unsigned S = 3;

  logic clk = 1'b0;
  logic rst;

  pipelined_wallace_multiplier_if #(.WIDTH(W)) bus ();

  pipelined_wallace_multiplier #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2*W-1:0] got_q[$];

  // Record every transfer out, mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(bus.result);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = 'x;
    if (idx < got_q.size()) got = 32'(got_q[idx]);
    check(tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    bus.in_valid  = 1'b1;
    bus.a         = x;
    bus.b         = y;
    bus.is_signed = s;
    step();
  endtask

  task automatic drain(input int n);
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  logic [W-1:0]   bp_a [5] = '{8'h01, 8'h0A, 8'h12, 8'hAB, 8'h40};
  logic [W-1:0]   bp_b [5] = '{8'h02, 8'h14, 8'h34, 8'hCD, 8'h40};
  logic [2*W-1:0] bp_p [5] = '{16'h0002, 16'h00C8, 16'h03A8, 16'h88EF, 16'h1000};

  initial begin
    int  sent;
    bit  fire;
    bit  stall;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    step();
    #1 check("in_ready_in_reset", 32'(bus.in_ready), 32'h1);
    step();
    rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check("reset_result", 32'(bus.result), 32'h0);
    check("reset_in_ready", 32'(bus.in_ready), 32'h1);

    // Latency: 3*5 accepted in cycle N, product visible in cycle N+3 only.
    bus.in_valid = 1'b1;
    bus.a        = 8'd3;
    bus.b        = 8'd5;
    #1 check("lat_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    bus.in_valid = 1'b0;
    #1 check("lat_n1_valid", 32'(bus.out_valid), 32'h0);
    step();
    #1 check("lat_n2_valid", 32'(bus.out_valid), 32'h0);
    step();
    #1;
    check("lat_n3_valid", 32'(bus.out_valid), 32'h1);
    check("lat_n3_result", 32'(bus.result), 32'h000F);
    step();
    #1 check("lat_single_emit", 32'(bus.out_valid), 32'h0);
    check("lat_count", 32'(got_q.size()), 32'd1);
    got_q.delete();

    // Boundary products back to back.
    send(8'hFF, 8'hFF, 1'b0);
    send(8'h80, 8'h80, 1'b1);
    send(8'hFF, 8'h01, 1'b1);
    send(8'h00, 8'hA5, 1'b1);
    send(8'h7F, 8'h80, 1'b1);
    drain(6);
    check("bnd_count", 32'(got_q.size()), 32'd5);
    check_q("umax_umax", 0, 32'hFE01);
    check_q("smin_smin", 1, 32'h4000);
    check_q("sneg1_x1", 2, 32'hFFFF);
    check_q("szero", 3, 32'h0000);
    check_q("smax_smin", 4, 32'hC080);
    got_q.delete();

    // Mixed signedness interleaved on identical operands.
    send(8'hFF, 8'hFF, 1'b1);
    send(8'hFF, 8'hFF, 1'b0);
    send(8'hFF, 8'hFF, 1'b1);
    drain(6);
    check("mix_count", 32'(got_q.size()), 32'd3);
    check_q("mix_s0", 0, 32'h0001);
    check_q("mix_u1", 1, 32'hFE01);
    check_q("mix_s2", 2, 32'h0001);
    got_q.delete();

    // Backpressure: consumer stalls in relative cycles 4..9 while 5 products stream.
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      stall         = (c >= 4) && (c <= 9);
      bus.out_ready = !stall;
      bus.in_valid  = (sent < 5);
      if (sent < 5) begin
        bus.a         = bp_a[sent];
        bus.b         = bp_b[sent];
        bus.is_signed = 1'b0;
      end
      #1;
      if (stall) begin
        check($sformatf("bp_in_ready_c%0d", c), 32'(bus.in_ready), 32'h0);
        check($sformatf("bp_hold_c%0d", c), 32'(bus.result), 32'(bp_p[1]));
      end
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (fire) sent++;
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_all_accepted", 32'(sent), 32'd5);
    check("bp_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) check_q($sformatf("bp_order_%0d", i), i, 32'(bp_p[i]));
    got_q.delete();

    // Reset with two products in flight discards both.
    send(8'h11, 8'h11, 1'b0);
    send(8'h22, 8'h22, 1'b0);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    #1 check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    rst = 1'b0;
    #1;
    check("rst_flush_valid", 32'(bus.out_valid), 32'h0);
    check("rst_flush_result", 32'(bus.result), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      #1 check($sformatf("rst_no_stale_%0d", i), 32'(bus.out_valid), 32'h0);
    end
    check("rst_none_emitted", 32'(got_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_wallace_multiplier.md
PIPELINED_WALLACE_MULTIPLIER -- requirements
Module: pipelined_wallace_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal 4..32).
REQ-002 The block SHALL have parameter STAGES, default 3, meaning pipeline register stages from input to result (legal 1..log2-reduction-depth+2).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the operand pair and mode are presented.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the operands this cycle.
REQ-007 The block SHALL have port a, input, WIDTH, meaning multiplicand.
REQ-008 The block SHALL have port b, input, WIDTH, meaning multiplier.
REQ-009 The block SHALL have port is_signed, input, 1, meaning 1 = two's-complement operands, 0 = unsigned.
REQ-010 The block SHALL have port out_valid, output, 1, meaning result holds a completed product.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes result this cycle.
REQ-012 The block SHALL have port result, output, 2*WIDTH, meaning the full-width product.

Function
REQ-013 Transfer in SHALL occur on a cycle with in_valid && in_ready; transfer out SHALL occur on a cycle with out_valid && out_ready.
REQ-014 The pipeline SHALL advance on every cycle where advance = !(out_valid && !out_ready); in_ready SHALL equal advance, combinationally.
REQ-015 When advance is 0, every stage register, including the valid bits and result, SHALL hold its value unchanged.
REQ-016 A transfer in at cycle N with no stall SHALL produce out_valid with its product at cycle N+STAGES, so the latency is STAGES cycles.
REQ-017 Throughput SHALL be one product per cycle with no stall; bubbles SHALL propagate and SHALL NOT be collapsed.
REQ-018 Results SHALL emerge in acceptance order; is_signed SHALL travel with its operands, so mixed modes may interleave back to back.
REQ-019 Partial products SHALL be a[i]&b[j]; signed mode SHALL use Baugh-Wooley correction, meaning inverted MSB-row/column terms plus constant 1s at bit positions WIDTH and 2*WIDTH-1.
REQ-020 Reduction SHALL be a Wallace tree of 3:2 full adders and 2:2 half adders down to two rows, with a final carry-propagate add; the result SHALL be exact modulo 2^(2*WIDTH).
REQ-021 Stage registers SHALL be placed at evenly spaced reduction levels; the final add SHALL always sit in the last stage.
REQ-022 Boundary cases SHALL be exact: unsigned max*max = 2^(2W)-2^(W+1)+1; signed min*min = 2^(2W-2) with no overflow; any operand 0 -> 0.
REQ-023 A product SHALL be accepted by the consumer exactly once; out_valid SHALL fall after a transfer out unless another product advances into the last stage.

Reset
REQ-024 On rst, every valid bit SHALL clear, giving out_valid=0 on the cycle after rst is sampled high.
REQ-025 result SHALL reset to 0; datapath registers other than result need not reset.
REQ-026 in_ready SHALL be 1 during and after reset, since no stall is possible with out_valid=0.
REQ-027 Reset mid-operation SHALL discard all in-flight products; none SHALL appear afterwards.

Structure
REQ-028 Package mul_pkg SHALL hold the default WIDTH and STAGES constants and a function computing the Wallace reduction depth for a given WIDTH.
REQ-029 A sub-module csa_row SHALL implement one carry-save 3:2 compression level over a parametrised bit vector, built from FA/HA cells; the tree SHALL be generated by instantiating it per level.
REQ-030 The pipeline control SHALL be a single advance signal shared by all stages, with no per-stage handshake.

Verification
REQ-031 WIDTH=8, STAGES=3, unsigned 3*5 -> result 0x000F, out_valid exactly 3 cycles after acceptance.
REQ-032 Unsigned 255*255 -> 0xFE01; signed 0x80*0x80 (-128*-128) -> 0x4000; signed 0xFF*0x01 -> 0xFFFF.
REQ-033 Backpressure: stream 5 products with out_ready=0 from cycle 4 to 9 -> in_ready=0 and result held while stalled, then all 5 products in order with none lost or duplicated.
REQ-034 Interleave is_signed 1,0,1 on 0xFF*0xFF -> 0x0001, 0xFE01, 0x0001.
REQ-035 Assert rst with 2 products in flight -> out_valid=0 next cycle and no stale product ever emitted.
REQ-036 Random 10^5 vectors with random stalls, for WIDTH in {4,8,16} and STAGES in {1,3}, against a behavioural product model -> zero mismatches.
